copperv_read_arbiter: RTL and testbench
=======================================

// Module: copperv_read_arbiter
// PURPOSE
//  Shares one memory read port between the CPU instruction-read (ir_*) and data-read (dr_*) channels.
//  Sits between the copperv core and the single-ported memory/bus model.
//  Arbitrates the address phase and records the source of each accepted request in an in-order route FIFO.
//  Steers each returning read datum back to the channel that issued it.
// PARAMETERS
//  ADDR_WIDTH       32  address width of all address ports
//  DATA_WIDTH       32  data width of all data ports
//  MAX_OUTSTANDING  4   route FIFO depth = max accepted-but-unreturned reads (power of 2, >=2)
// PORTS
//  clk            in   1                          system clock, all logic on posedge
//  rst            in   1                          synchronous reset, active-low
//  ir_addr_valid  in   1                          instruction fetch request
//  ir_addr_ready  out  1                          fetch request accepted
//  ir_addr        in   ADDR_WIDTH                 fetch address
//  ir_data_valid  out  1                          fetch data available
//  ir_data_ready  in   1                          core accepts fetch data
//  ir_data        out  DATA_WIDTH                 fetch data
//  dr_addr_valid  in   1                          load request
//  dr_addr_ready  out  1                          load request accepted
//  dr_addr        in   ADDR_WIDTH                 load address
//  dr_data_valid  out  1                          load data available
//  dr_data_ready  in   1                          core accepts load data
//  dr_data        out  DATA_WIDTH                 load data
//  m_addr_valid   out  1                          memory read request
//  m_addr_ready   in   1                          memory accepts request
//  m_addr         out  ADDR_WIDTH                 memory read address
//  m_data_valid   in   1                          memory read data available
//  m_data_ready   out  1                          arbiter accepts memory data
//  m_data         in   DATA_WIDTH                 memory read data
//  outstanding    out  $clog2(MAX_OUTSTANDING)+1  current route FIFO occupancy
// BEHAVIOUR
//  - Handshake: transfer occurs when valid & ready are both high at posedge clk.
//  - Reset (rst==0 at posedge): route FIFO emptied, outstanding=0, lock cleared, RR pointer=ir.
//    All *_valid/*_ready outputs are 0 while rst==0. Reset mid-transaction drops in-flight responses.
//    Memory is reset with the arbiter.
//  - Address phase (combinational, zero latency):
//    - full = (outstanding==MAX_OUTSTANDING), registered count only.
//    - A pop in the same cycle does NOT unblock a push.
//    - m_addr_valid = !full & (granted channel valid). m_addr = granted address.
//    - Granted addr_ready = m_addr_ready & !full. Non-granted addr_ready = 0.
//  - Grant lock:
//    - If m_addr_valid=1 and m_addr_ready=0, the grant is latched.
//    - While latched, the grant holds until that handshake, even if the other channel asserts.
//      m_addr stays stable.
//    - The lock clears on the handshake.
//  - On each address handshake, push source id (0=ir, 1=dr). Back-to-back accepts every cycle are allowed.
//  - Data phase (combinational):
//    - FIFO head selects the destination.
//    - ir_data_valid = m_data_valid & !empty & head==0. dr_data_valid is the same with head==1.
//    - m_data_ready = !empty & selected data_ready.
//    - m_data is driven to both ir_data and dr_data.
//    - A datum handshake pops the head.
//    - A non-head channel never sees valid, so head-of-line blocking is intended.
//  - m_data_valid with the FIFO empty: m_data_ready=0 and no valid is forwarded (protocol error, ignored).
//  - Push and pop in the same cycle: outstanding unchanged, pointers wrap modulo MAX_OUTSTANDING.
//  - Minimum latency from address accept to data forward is set by memory. The arbiter adds 0 cycles.
// CONFIGURATION
//  - ARB_RR_EN defined: round-robin arbitration.
//    - With both channels requesting and unlocked, the channel not granted last wins.
//    - The pointer updates only on an address handshake.
//  - ARB_RR_EN undefined: fixed priority, dr over ir. ir waits while dr_addr_valid=1 unless ir is locked.
// TESTING
//  1. rst=0 for 3 cycles with ir_addr_valid=1, m_addr_ready=1 -> m_addr_valid=0, ir_addr_ready=0, outstanding=0.
//  2. ir fetch 0x00000000; memory returns 0x00000013 two cycles later
//     -> ir_data_valid=1, ir_data=0x13, dr_data_valid=0, outstanding 1->0.
//  3. ir 0x100 and dr 0x2000 valid in the same cycle, no RR
//     -> dr accepted first, ir next cycle, FIFO order dr,ir.
//     With ARB_RR_EN after a prior ir grant -> dr first, then ir, then alternate.
//  4. MAX_OUTSTANDING=4, four fetches accepted, m_data_valid=0
//     -> 5th gets ir_addr_ready=0, outstanding=4.
//     One datum returned -> 5th accepted on the following cycle.
//  5. ir valid at 0x40, m_addr_ready=0 for 3 cycles, dr valid from cycle 2
//     -> m_addr=0x40 stable, ir granted at release, dr next.
//  6. Responses queued ir,dr; ir_data_ready=0 for 2 cycles
//     -> m_data_ready=0, dr_data_valid=0, until ir accepts.

Source files
------------

// File: rtl/copperv_read_arbiter.sv
// copperv_read_arbiter
// Shares one memory read port between the instruction-read (ir) and data-read
// (dr) channels. Each accepted address records its source in an in-order route
// FIFO. The FIFO head then steers every returning datum back to its requester.
// Build option: define ARB_RR_EN for round-robin arbitration. Without it,
// arbitration is fixed priority with dr over ir.
// Handshake rule: a transfer happens on a posedge where valid and ready are both
// high. A valid, once raised, is expected to hold until its transfer.
module copperv_read_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               ir_addr_valid,
    output logic                               ir_addr_ready,
    input  logic [ADDR_WIDTH-1:0]              ir_addr,
    output logic                               ir_data_valid,
    input  logic                               ir_data_ready,
    output logic [DATA_WIDTH-1:0]              ir_data,
    input  logic                               dr_addr_valid,
    output logic                               dr_addr_ready,
    input  logic [ADDR_WIDTH-1:0]              dr_addr,
    output logic                               dr_data_valid,
    input  logic                               dr_data_ready,
    output logic [DATA_WIDTH-1:0]              dr_data,
    output logic                               m_addr_valid,
    input  logic                               m_addr_ready,
    output logic [ADDR_WIDTH-1:0]              m_addr,
    input  logic                               m_data_valid,
    output logic                               m_data_ready,
    input  logic [DATA_WIDTH-1:0]              m_data,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic SRC_IR = 1'b0;
    localparam logic SRC_DR = 1'b1;

    logic [MAX_OUTSTANDING-1:0] route_q, route_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       lock_q, lock_d;
    logic                       lock_src_q, lock_src_d;
`ifdef ARB_RR_EN
    logic                       rr_prio_q, rr_prio_d;
`endif

    logic grant;
    logic req_valid;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;
    logic sel_ready;

    // Pick the channel that owns the address phase; a latched grant always wins
    always_comb begin
        grant = SRC_IR;
        if (lock_q) begin
            grant = lock_src_q;
`ifdef ARB_RR_EN
        end else if (ir_addr_valid && dr_addr_valid) begin
            grant = rr_prio_q;
`endif
        end else if (dr_addr_valid) begin
            grant = SRC_DR;
        end
    end

    // Address and data phase steering, all outputs held low during reset
    always_comb begin
        full          = (count_q == CNT_W'(MAX_OUTSTANDING));
        empty         = (count_q == '0);
        req_valid     = grant ? dr_addr_valid : ir_addr_valid;
        m_addr        = grant ? dr_addr : ir_addr;
        m_addr_valid  = rst && !full && req_valid;
        ir_addr_ready = rst && !full && m_addr_ready && (grant == SRC_IR);
        dr_addr_ready = rst && !full && m_addr_ready && (grant == SRC_DR);
        push          = m_addr_valid && m_addr_ready;

        head          = route_q[rd_ptr_q];
        sel_ready     = head ? dr_data_ready : ir_data_ready;
        ir_data_valid = rst && m_data_valid && !empty && (head == SRC_IR);
        dr_data_valid = rst && m_data_valid && !empty && (head == SRC_DR);
        m_data_ready  = rst && !empty && sel_ready;
        pop           = m_data_valid && m_data_ready;

        ir_data       = m_data;
        dr_data       = m_data;
        outstanding   = count_q;
    end

    // Next state for route FIFO, grant lock and round-robin pointer
    always_comb begin
        route_d  = route_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            route_d[wr_ptr_q] = grant;
        end
        // A presented but stalled request keeps its grant until it transfers
        lock_d     = m_addr_valid && !m_addr_ready;
        lock_src_d = grant;
`ifdef ARB_RR_EN
        rr_prio_d = push ? ~grant : rr_prio_q;
`endif
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            route_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_IR;
`ifdef ARB_RR_EN
            rr_prio_q  <= SRC_IR;
`endif
        end else begin
            route_q    <= route_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
`ifdef ARB_RR_EN
            rr_prio_q  <= rr_prio_d;
`endif
        end
    end

endmodule

// File: tb/tb_copperv_read_arbiter.sv
// Testbench for copperv_read_arbiter.
// Random requesters and a random in-order memory drive the block. An abstract
// model predicts every output. That model keeps the outstanding reads as a
// queue of source ids and applies the arbitration rules directly. Returned data
// is scoreboarded per channel.
module tb_copperv_read_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int CW = $clog2(MO) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
    logic [AW-1:0] ir_addr;
    logic [DW-1:0] ir_data;
    logic          dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
    logic [AW-1:0] dr_addr;
    logic [DW-1:0] dr_data;
    logic          m_addr_valid, m_addr_ready, m_data_valid, m_data_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [CW-1:0] outstanding;

    copperv_read_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
        .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
        .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
        .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
        .m_addr_valid(m_addr_valid), .m_addr_ready(m_addr_ready), .m_addr(m_addr),
        .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data(m_data),
        .outstanding(outstanding)
    );

    // Clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int            route_q[$];        // source of each accepted, unreturned read
    logic [DW-1:0] mem_q[$];          // data the memory still owes, in order
    logic [DW-1:0] ir_exp_q[$];       // scoreboard: data ir must receive
    logic [DW-1:0] dr_exp_q[$];       // scoreboard: data dr must receive
    int            lock_ch = -1;      // channel holding a stalled grant
    int            last_ch = 1;       // last granted channel (ir wins the first tie)
    bit            ir_ahs, dr_ahs, m_dhs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13;
    endfunction

    // Predict outputs for the current inputs, then advance the model to the next edge
    task automatic eval_cycle();
        int winner;
        int head;
        bit full, nonempty;
        bit e_mav, e_ira, e_dra, e_ird, e_drd, e_mdr;
        full     = (route_q.size() == MO);
        nonempty = (route_q.size() != 0);
        head     = nonempty ? route_q[0] : 0;
        winner   = -1;
        if (lock_ch >= 0) winner = lock_ch;
        else if (ir_addr_valid && dr_addr_valid) begin
`ifdef ARB_RR_EN
            winner = (last_ch == 0) ? 1 : 0;
`else
            winner = 1;
`endif
        end
        else if (dr_addr_valid) winner = 1;
        else if (ir_addr_valid) winner = 0;

        e_mav = rst && !full && (winner >= 0);
        e_ira = rst && !full && m_addr_ready && (winner == 0);
        e_dra = rst && !full && m_addr_ready && (winner == 1);
        e_ird = rst && m_data_valid && nonempty && (head == 0);
        e_drd = rst && m_data_valid && nonempty && (head == 1);
        e_mdr = rst && nonempty && ((head == 0) ? ir_data_ready : dr_data_ready);

        check("outstanding", 64'(outstanding), 64'(route_q.size()));
        check("m_addr_valid", 64'(m_addr_valid), 64'(e_mav));
        if (e_mav) check("m_addr", 64'(m_addr), 64'((winner == 1) ? dr_addr : ir_addr));
        if (ir_addr_valid) check("ir_addr_ready", 64'(ir_addr_ready), 64'(e_ira));
        if (dr_addr_valid) check("dr_addr_ready", 64'(dr_addr_ready), 64'(e_dra));
        check("ir_data_valid", 64'(ir_data_valid), 64'(e_ird));
        check("dr_data_valid", 64'(dr_data_valid), 64'(e_drd));
        check("m_data_ready", 64'(m_data_ready), 64'(e_mdr));

        ir_ahs = e_ira && ir_addr_valid;
        dr_ahs = e_dra && dr_addr_valid;
        m_dhs  = m_data_valid && e_mdr;

        if (e_ird && ir_data_ready && ir_exp_q.size() > 0)
            check("ir_data", 64'(ir_data), 64'(ir_exp_q.pop_front()));
        if (e_drd && dr_data_ready && dr_exp_q.size() > 0)
            check("dr_data", 64'(dr_data), 64'(dr_exp_q.pop_front()));

        if (!rst) begin
            route_q.delete(); mem_q.delete(); ir_exp_q.delete(); dr_exp_q.delete();
            lock_ch = -1;
            last_ch = 1;
            ir_ahs = 0; dr_ahs = 0; m_dhs = 0;
        end else begin
            if (m_dhs) begin
                void'(route_q.pop_front());
                void'(mem_q.pop_front());
            end
            if (ir_ahs) begin
                route_q.push_back(0);
                mem_q.push_back(mem_fn(ir_addr));
                ir_exp_q.push_back(mem_fn(ir_addr));
                last_ch = 0;
            end
            if (dr_ahs) begin
                route_q.push_back(1);
                mem_q.push_back(mem_fn(dr_addr));
                dr_exp_q.push_back(mem_fn(dr_addr));
                last_ch = 1;
            end
            lock_ch = (e_mav && !m_addr_ready) ? winner : -1;
        end
    endtask

    // Driver: requesters and memory hold valid until their transfer
    task automatic drive(input int p_req, input int p_mar, input int p_mdv, input int p_rdy);
        if (!ir_addr_valid || ir_ahs) begin
            ir_addr_valid = ($urandom_range(99) < p_req);
            ir_addr       = {$urandom} & ~32'h3;
        end
        if (!dr_addr_valid || dr_ahs) begin
            dr_addr_valid = ($urandom_range(99) < p_req);
            dr_addr       = {$urandom} & ~32'h3;
        end
        if (!m_data_valid || m_dhs || mem_q.size() == 0) begin
            if (mem_q.size() > 0 && $urandom_range(99) < p_mdv) begin
                m_data_valid = 1'b1;
                m_data       = mem_q[0];
            end else if (mem_q.size() == 0 && $urandom_range(99) < 3) begin
                m_data_valid = 1'b1;          // stray datum with nothing outstanding
                m_data       = $urandom;
            end else begin
                m_data_valid = 1'b0;
            end
        end
        m_addr_ready  = ($urandom_range(99) < p_mar);
        ir_data_ready = ($urandom_range(99) < p_rdy);
        dr_data_ready = ($urandom_range(99) < p_rdy);
    endtask

    task automatic step();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        #1;
    endtask

    // Phase knobs: request %, m_addr_ready %, m_data_valid %, data_ready %
    int ph[6][4] = '{'{70, 80, 60, 80}, '{90, 90, 5, 90}, '{90, 20, 70, 50},
                     '{50, 50, 50, 20}, '{95, 100, 100, 100}, '{30, 60, 40, 70}};

    initial begin
        rst = 1'b0;
        ir_addr_valid = 1'b1; ir_addr = '0; ir_data_ready = 1'b0;
        dr_addr_valid = 1'b0; dr_addr = '0; dr_data_ready = 1'b0;
        m_addr_ready = 1'b1; m_data_valid = 1'b0; m_data = '0;
        ir_ahs = 0; dr_ahs = 0; m_dhs = 0;
        @(posedge clk);
        #1;
        repeat (3) step();
        rst = 1'b1;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 300; c++) begin
                drive(ph[p][0], ph[p][1], ph[p][2], ph[p][3]);
                step();
            end
            if (p == 2) begin
                rst = 1'b0;
                repeat (2) begin
                    drive(ph[p][0], ph[p][1], ph[p][2], ph[p][3]);
                    step();
                end
                rst = 1'b1;
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
